bloco_controle: RTL and testbench

//  Control unit driving the datapath block (register bank + ULA + flag register) from the opposite side.
//  - Fetches 16-bit instructions over a req/ack interface and decodes them.
//  - Issues register selects, ULA operation code and write strobes to the datapath.
//  - Resolves conditional branches from the datapath ZCSO flags.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_ret_stack.sv | 52 +++++
 rtl/bloco_controle.sv | 183 ++++++++++++++++++
 tb/tb_bloco_controle.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the bloco_controle control unit: opcodes, branch
// conditions, FSM states and the branch-condition evaluator.
package ctrl_pkg;

   // ALU opcodes occupy 5'h00..5'h17; everything from OP_ALU_LIMIT up is control.
   localparam logic [4:0] OP_ALU_LIMIT = 5'h18;
   localparam logic [4:0] OP_CMP       = 5'h0F;
   localparam logic [4:0] OP_CALL      = 5'h1A;
   localparam logic [4:0] OP_RET       = 5'h1B;
   localparam logic [4:0] OP_BR        = 5'h1C;
   localparam logic [4:0] OP_NOP       = 5'h1E;
   localparam logic [4:0] OP_HALT      = 5'h1F;

   localparam int unsigned RET_DEPTH = 4;

   typedef enum logic [2:0] {
      CondAlways = 3'b000,
      CondZ      = 3'b001,
      CondC      = 3'b010,
      CondS      = 3'b011,
      CondO      = 3'b100,
      CondNz     = 3'b101
   } cond_e;

   typedef enum logic [2:0] {
      StInit,
      StFetch,
      StDecode,
      StExec,
      StHalt
   } state_e;

   // Codes 3'b110 and 3'b111 are reserved and make the branch illegal.
   function automatic logic cond_legal(input logic [2:0] cond);
      return cond <= 3'b101;
   endfunction

   // flags = {Z, C, S, O}
   function automatic logic cond_taken(input cond_e cond, input logic [3:0] flags);
      logic taken;
      case (cond)
         CondAlways: taken = 1'b1;
         CondZ:      taken = flags[3];
         CondC:      taken = flags[2];
         CondS:      taken = flags[1];
         CondO:      taken = flags[0];
         CondNz:     taken = ~flags[3];
         default:    taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ctrl_ret_stack.sv
// Return-address stack for CALL/RET. Only instantiated when CTRL_CALL_EN is
// defined. Caller must not push when full or pop when empty; those requests
// are ignored here and reported as faults by the control FSM.
module ctrl_ret_stack #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] pop_data,
   output logic            full,
   output logic            empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  mem_q [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign top_idx  = count_q - CNT_W'(1);
   assign wr_ptr   = PTR_W'(count_q);
   assign rd_ptr   = PTR_W'(top_idx);
   assign pop_data = mem_q[rd_ptr];

   // Occupancy counter; guarded push/pop never over- or underflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (push && !full) begin
         count_q <= count_q + CNT_W'(1);
      end else if (pop && !empty) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/bloco_controle.sv
// Control unit for the register-bank / ULA / flag-register datapath.
// Fetches 16-bit instructions over req/ack, decodes them and drives register
// selects, ULA opcode and write strobes; branches resolve on Flags_ZCSO.
// Optional feature: define CTRL_CALL_EN for CALL/RET with a 4-entry return
// stack; otherwise opcodes 5'h1A/5'h1B are illegal.
module bloco_controle
   import ctrl_pkg::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned end_regs = 4
) (
   input  logic                clk,
   input  logic                reset,
   output logic                instr_req,
   output logic [PC_W-1:0]     instr_addr,
   input  logic                instr_ack,
   input  logic [15:0]         instr_data,
   input  logic [3:0]          Flags_ZCSO,
   output logic [end_regs-1:0] Sel_SA,
   output logic [end_regs-1:0] Sel_SB,
   output logic [4:0]          controleOperacao,
   output logic                Hab_Escrita,
   output logic                en,
   output logic                reset_Ban_Registros,
   output logic                reset_Flags,
   output logic                halted,
   output logic                err
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic                err_q, err_d;
   logic [15:0]         instr_q;
   logic [end_regs-1:0] sel_sa_q, sel_sb_q;
   logic [4:0]          op_q;

   // Decode of the latched instruction
   logic [4:0]      op;
   logic [2:0]      cond;
   logic            is_alu, is_br, is_nop, is_halt, is_call, is_ret;
   logic            br_ok, br_taken, stack_fault, illegal;
   logic [PC_W-1:0] pc_plus_one, target_pc, ret_pc;

   assign op          = instr_q[15:11];
   assign cond        = instr_q[10:8];
   assign is_alu      = (op < OP_ALU_LIMIT);
   assign is_br       = (op == OP_BR);
   assign is_nop      = (op == OP_NOP);
   assign is_halt     = (op == OP_HALT);
   assign br_ok       = cond_legal(cond);
   assign br_taken    = cond_taken(cond_e'(cond), Flags_ZCSO);
   assign pc_plus_one = pc_q + PC_W'(1);
   assign target_pc   = PC_W'(instr_q[7:0]);

`ifdef CTRL_CALL_EN
   logic stk_push, stk_pop, stk_full, stk_empty;

   assign is_call     = (op == OP_CALL);
   assign is_ret      = (op == OP_RET);
   assign stack_fault = (is_call && stk_full) || (is_ret && stk_empty);
   assign stk_push    = (state_q == StDecode) && is_call && !stk_full;
   assign stk_pop     = (state_q == StDecode) && is_ret && !stk_empty;

   ctrl_ret_stack #(
      .PC_W  (PC_W),
      .DEPTH (RET_DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_plus_one),
      .pop_data  (ret_pc),
      .full      (stk_full),
      .empty     (stk_empty)
   );
`else
   assign is_call     = 1'b0;
   assign is_ret      = 1'b0;
   assign stack_fault = 1'b0;
   assign ret_pc      = '0;
`endif

   // Anything not recognised (including reserved branch conditions) faults.
   assign illegal = !(is_alu || is_nop || is_halt || (is_br && br_ok) || is_call || is_ret)
                    || stack_fault;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, next-pc and fault logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = err_q;
      case (state_q)
         StInit: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (instr_ack) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (illegal) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else if (is_halt) begin
               state_d = StHalt;
            end else if (is_alu) begin
               state_d = StExec;
            end else begin
               state_d = StFetch;
               if ((is_br && br_taken) || is_call) begin
                  pc_d = target_pc;
               end else if (is_ret) begin
                  pc_d = ret_pc;
               end else begin
                  pc_d = pc_plus_one;
               end
            end
         end
         StExec: begin
            state_d = StFetch;
            pc_d    = pc_plus_one;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   // Program counter, instruction latch, sticky error and held datapath selects
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= '0;
         err_q    <= 1'b0;
         instr_q  <= '0;
         sel_sa_q <= '0;
         sel_sb_q <= '0;
         op_q     <= '0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
         if (state_q == StFetch && instr_ack) begin
            instr_q <= instr_data;
         end
         // Load on the DECODE->EXEC edge so the values hold after EXEC ends.
         if (state_q == StDecode && is_alu) begin
            sel_sa_q <= end_regs'(instr_q[10:7]);
            sel_sb_q <= end_regs'(instr_q[6:3]);
            op_q     <= op;
         end
      end
   end

   // Outputs from state register and latched instruction only
   always_comb begin
      instr_req           = (state_q == StFetch);
      instr_addr          = pc_q;
      Sel_SA              = sel_sa_q;
      Sel_SB              = sel_sb_q;
      controleOperacao    = op_q;
      en                  = (state_q == StExec);
      Hab_Escrita         = (state_q == StExec) && (op_q != OP_CMP);
      // Clear pulses stay low while reset is held; they fire in the INIT cycle.
      reset_Ban_Registros = (state_q == StInit) && reset;
      reset_Flags         = (state_q == StInit) && reset;
      halted              = (state_q == StHalt);
      err                 = err_q;
   end

endmodule

// File: tb/tb_bloco_controle.sv
// Self-checking bench for bloco_controle: a memory responder serves fetches,
// directed programs push expected fetch addresses and EXEC strobes into
// queues, and a monitor pops and compares as the DUT presents them.
module tb_bloco_controle;

   typedef struct packed {
      logic [3:0] sa;
      logic [3:0] sb;
      logic [4:0] op;
      logic       hab;
   } exec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_req;
   logic [7:0]  instr_addr;
   logic        instr_ack = 1'b0;
   logic [15:0] instr_data = '0;
   logic [3:0]  Flags_ZCSO = '0;
   logic [3:0]  Sel_SA, Sel_SB;
   logic [4:0]  controleOperacao;
   logic        Hab_Escrita, en, reset_Ban_Registros, reset_Flags, halted, err;

   logic [15:0] mem [256];
   logic [7:0]  exp_addr_q [$];
   exec_t       exp_exec_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ack_delay = 0;
   logic        auto_ack  = 1'b1;

   bloco_controle #(
      .PC_W     (8),
      .end_regs (4)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .instr_req           (instr_req),
      .instr_addr          (instr_addr),
      .instr_ack           (instr_ack),
      .instr_data          (instr_data),
      .Flags_ZCSO          (Flags_ZCSO),
      .Sel_SA              (Sel_SA),
      .Sel_SB              (Sel_SB),
      .controleOperacao    (controleOperacao),
      .Hab_Escrita         (Hab_Escrita),
      .en                  (en),
      .reset_Ban_Registros (reset_Ban_Registros),
      .reset_Flags         (reset_Flags),
      .halted              (halted),
      .err                 (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc_alu(input logic [4:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs);
      return {op, rd, rs, 3'b000};
   endfunction

   function automatic logic [15:0] enc_br(input logic [2:0] cond, input logic [7:0] tgt);
      return {5'h1C, cond, tgt};
   endfunction

   function automatic logic [15:0] enc_tgt(input logic [4:0] op, input logic [7:0] tgt);
      return {op, 3'b000, tgt};
   endfunction

   // Memory responder: acks a pending request after ack_delay idle cycles.
   initial begin
      int wait_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (auto_ack) begin
            if (instr_ack) begin
               instr_ack = 1'b0;
               wait_cnt  = 0;
            end else if (instr_req) begin
               if (wait_cnt >= ack_delay) begin
                  instr_ack  = 1'b1;
                  instr_data = mem[instr_addr];
                  wait_cnt   = 0;
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: compares fetch handshakes and EXEC cycles against the queues.
   initial begin
      logic       prev_req  = 1'b0;
      logic       prev_ack  = 1'b0;
      logic [7:0] prev_addr = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (instr_req && prev_req && !prev_ack) begin
               check("addr_stable_while_waiting", instr_addr, prev_addr);
            end
            if (instr_req && instr_ack) begin
               if (exp_addr_q.size() == 0) begin
                  check("unexpected_fetch", instr_addr, 32'hFFFF_FFFF);
               end else begin
                  check("fetch_addr", instr_addr, exp_addr_q.pop_front());
               end
            end
            if (en) begin
               if (exp_exec_q.size() == 0) begin
                  check("unexpected_exec", {Sel_SA, Sel_SB, controleOperacao, Hab_Escrita},
                        32'hFFFF_FFFF);
               end else begin
                  check("exec_strobes", {Sel_SA, Sel_SB, controleOperacao, Hab_Escrita},
                        exp_exec_q.pop_front());
               end
            end else begin
               check("hab_low_outside_exec", Hab_Escrita, 1'b0);
            end
            prev_req  = instr_req;
            prev_ack  = instr_ack;
            prev_addr = instr_addr;
         end else begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF800;  // HALT everywhere
      exp_addr_q.delete();
      exp_exec_q.delete();
   endtask

   // Hold reset two cycles, check reset outputs, release on a falling edge.
   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b0;
      instr_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr_req", instr_req, 1'b0);
      check("rst_addr", instr_addr, 8'h00);
      check("rst_en_hab", {en, Hab_Escrita}, 2'b00);
      check("rst_halted_err", {halted, err}, 2'b00);
      check("rst_pulses_low", {reset_Ban_Registros, reset_Flags}, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("init_pulses", {reset_Ban_Registros, reset_Flags}, 2'b11);
      @(posedge clk);
      #1;
      check("init_one_cycle", {reset_Ban_Registros, reset_Flags}, 2'b00);
   endtask

   task automatic finish_scenario(input string name, input logic exp_err);
      int i = 0;
      while (!halted && i < 300) begin
         @(negedge clk);
         i++;
      end
      check({name, "_halt_reached"}, halted, 1'b1);
      check({name, "_err"}, err, exp_err);
      repeat (3) @(negedge clk);
      check({name, "_fetches_done"}, exp_addr_q.size(), 0);
      check({name, "_execs_done"}, exp_exec_q.size(), 0);
   endtask

   initial begin
      // ALU op 5'h01 rd=3 rs=2 with zero-wait ack, then HALT at pc=1
      clear_mem();
      ack_delay = 0;
      mem[0] = enc_alu(5'h01, 4'd3, 4'd2);
      exp_addr_q = '{8'h00, 8'h01};
      exp_exec_q.push_back('{sa: 4'd3, sb: 4'd2, op: 5'h01, hab: 1'b1});
      apply_reset();
      repeat (2) @(posedge clk);
      #1;
      check("exec_at_third_cycle", en, 1'b1);
      finish_scenario("alu_basic", 1'b0);
      check("selects_hold", {Sel_SA, Sel_SB, controleOperacao}, {4'd3, 4'd2, 5'h01});

      // Ack delayed 5 cycles: request stable, exactly one EXEC
      clear_mem();
      ack_delay = 5;
      mem[0] = enc_alu(5'h02, 4'd1, 4'd4);
      exp_addr_q = '{8'h00, 8'h01};
      exp_exec_q.push_back('{sa: 4'd1, sb: 4'd4, op: 5'h02, hab: 1'b1});
      apply_reset();
      finish_scenario("slow_ack", 1'b0);
      ack_delay = 0;

      // CMP then BR Z taken
      clear_mem();
      Flags_ZCSO = 4'b1000;
      mem[0] = enc_alu(5'h0F, 4'd5, 4'd6);
      mem[1] = enc_br(3'b001, 8'h40);
      exp_addr_q = '{8'h00, 8'h01, 8'h40};
      exp_exec_q.push_back('{sa: 4'd5, sb: 4'd6, op: 5'h0F, hab: 1'b0});
      apply_reset();
      finish_scenario("br_z_taken", 1'b0);

      // CMP then BR Z not taken
      clear_mem();
      Flags_ZCSO = 4'b0000;
      mem[0] = enc_alu(5'h0F, 4'd5, 4'd6);
      mem[1] = enc_br(3'b001, 8'h40);
      exp_addr_q = '{8'h00, 8'h01, 8'h02};
      exp_exec_q.push_back('{sa: 4'd5, sb: 4'd6, op: 5'h0F, hab: 1'b0});
      apply_reset();
      finish_scenario("br_z_not_taken", 1'b0);

      // BR !Z to 8'hFF, NOP wraps pc to 0, then BR !Z falls through once Z=1
      clear_mem();
      Flags_ZCSO = 4'b0000;
      mem[0]    = enc_br(3'b101, 8'hFF);
      mem[8'hFF] = 16'hF000;
      exp_addr_q = '{8'h00, 8'hFF, 8'h00, 8'h01};
      apply_reset();
      begin
         int i = 0;
         while (exp_addr_q.size() > 2 && i < 100) begin
            @(negedge clk);
            i++;
         end
         check("wrap_progress", exp_addr_q.size(), 2);
      end
      Flags_ZCSO = 4'b1000;
      finish_scenario("pc_wrap", 1'b0);
      Flags_ZCSO = 4'b0000;

      // Illegal opcode 5'h1D: sticky halt with err, no further requests
      clear_mem();
      mem[0] = enc_tgt(5'h1D, 8'h00);
      exp_addr_q = '{8'h00};
      apply_reset();
      finish_scenario("illegal_op", 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("halt_no_req", {instr_req, en, halted, err}, 4'b0011);
      end

      // Reserved branch condition is illegal
      clear_mem();
      mem[0] = enc_br(3'b110, 8'h20);
      exp_addr_q = '{8'h00};
      apply_reset();
      finish_scenario("illegal_cond", 1'b1);

`ifdef CTRL_CALL_EN
      // Five nested CALLs overflow the 4-entry stack
      clear_mem();
      mem[8'h00] = enc_tgt(5'h1A, 8'h10);
      mem[8'h10] = enc_tgt(5'h1A, 8'h20);
      mem[8'h20] = enc_tgt(5'h1A, 8'h30);
      mem[8'h30] = enc_tgt(5'h1A, 8'h40);
      mem[8'h40] = enc_tgt(5'h1A, 8'h50);
      exp_addr_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
      apply_reset();
      finish_scenario("call_overflow", 1'b1);

      // CALL then RET returns to pc+1
      clear_mem();
      mem[8'h00] = enc_tgt(5'h1A, 8'h10);
      mem[8'h10] = enc_tgt(5'h1B, 8'h00);
      exp_addr_q = '{8'h00, 8'h10, 8'h01};
      apply_reset();
      finish_scenario("call_ret", 1'b0);
`else
      // Without the return stack CALL is illegal
      clear_mem();
      mem[0] = enc_tgt(5'h1A, 8'h10);
      exp_addr_q = '{8'h00};
      apply_reset();
      finish_scenario("call_disabled", 1'b1);
`endif

      // Reset mid-FETCH with a stray ack: ignored, restart at pc=0
      clear_mem();
      ack_delay = 10;
      mem[0] = 16'hF000;
      apply_reset();
      repeat (3) @(negedge clk);
      check("fetch_pending", instr_req, 1'b1);
      auto_ack = 1'b0;
      reset    = 1'b0;
      #1;
      check("reset_drops_req", instr_req, 1'b0);
      instr_data = enc_alu(5'h01, 4'd7, 4'd7);
      instr_ack  = 1'b1;
      exp_addr_q = '{8'h00, 8'h01};
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      instr_ack = 1'b0;
      ack_delay = 0;
      auto_ack  = 1'b1;
      check("restart_addr", instr_addr, 8'h00);
      finish_scenario("reset_mid_fetch", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
